// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - HD44780 read-cycle engine (BF/AC and data reads); optional auto-poll via LCD_READER_AUTOPOLL_EN
module lcd_reader #(
    parameter int SETUP_CYC   = 20,
    parameter int EN_HIGH_CYC = 75,
    parameter int SAMPLE_CYC  = 40,
    parameter int HOLD_CYC    = 20,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_rs,
`ifdef LCD_READER_AUTOPOLL_EN
    input  logic       poll_req,
    output logic       lcd_idle,
`endif
    output logic       ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    input  logic [7:0] LCD_DataBus_in,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       bus_oe
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EN_HI, S_HOLD} state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT  = CNT_W'(SAMPLE_CYC);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             en_q, en_n;
    logic             rw_q, rw_n;
    logic             rs_q, rs_n;
    logic             oe_q, oe_n;
    logic             rv_q, rv_n;
    logic [7:0]       data_q, data_n;
    logic             bf_q, bf_n;
    logic [6:0]       ac_q, ac_n;
`ifdef LCD_READER_AUTOPOLL_EN
    logic             poll_q, poll_n;
    logic             idle_q, idle_n;
`endif

    // State and output registers; reset drops EN immediately and clears stored results
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            en_q   <= 1'b0;
            rw_q   <= 1'b0;
            rs_q   <= 1'b0;
            oe_q   <= 1'b1;
            rv_q   <= 1'b0;
            data_q <= 8'h00;
            bf_q   <= 1'b1;
            ac_q   <= 7'h00;
`ifdef LCD_READER_AUTOPOLL_EN
            poll_q <= 1'b0;
            idle_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            en_q   <= en_n;
            rw_q   <= rw_n;
            rs_q   <= rs_n;
            oe_q   <= oe_n;
            rv_q   <= rv_n;
            data_q <= data_n;
            bf_q   <= bf_n;
            ac_q   <= ac_n;
`ifdef LCD_READER_AUTOPOLL_EN
            poll_q <= poll_n;
            idle_q <= idle_n;
`endif
        end
    end

    // Next-state logic: each phase counts its length, counter restarts on every transition
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        en_n    = en_q;
        rw_n    = rw_q;
        rs_n    = rs_q;
        oe_n    = oe_q;
        rv_n    = 1'b0;
        data_n  = data_q;
        bf_n    = bf_q;
        ac_n    = ac_q;
`ifdef LCD_READER_AUTOPOLL_EN
        poll_n  = poll_q;
        idle_n  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                en_n  = 1'b0;
`ifdef LCD_READER_AUTOPOLL_EN
                if (poll_req) begin
                    rs_n    = 1'b0;
                    rw_n    = 1'b1;
                    oe_n    = 1'b0;
                    poll_n  = 1'b1;
                    state_n = S_SETUP;
                end else
`endif
                if (req) begin
                    rs_n    = req_rs;
                    rw_n    = 1'b1;
                    oe_n    = 1'b0;
                    state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    en_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = S_EN_HI;
                end
            end
            S_EN_HI: begin
                if (cnt == SAMPLE_AT) begin
                    data_n = LCD_DataBus_in;
                    if (!rs_q) begin
                        bf_n = LCD_DataBus_in[7];
                        ac_n = LCD_DataBus_in[6:0];
                    end
                end
                if (cnt == EN_LAST) begin
                    en_n    = 1'b0;
                    rv_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = S_HOLD;
`ifdef LCD_READER_AUTOPOLL_EN
                    idle_n  = poll_q && !bf_n;
`endif
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n = '0;
`ifdef LCD_READER_AUTOPOLL_EN
                    // Still busy: go straight back to SETUP with RW held high
                    if (poll_q && bf_q) begin
                        state_n = S_SETUP;
                    end else begin
                        poll_n  = 1'b0;
                        rw_n    = 1'b0;
                        oe_n    = 1'b1;
                        state_n = S_IDLE;
                    end
`else
                    rw_n    = 1'b0;
                    oe_n    = 1'b1;
                    state_n = S_IDLE;
`endif
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign ready     = (state == S_IDLE);
    assign rd_valid  = rv_q;
    assign rd_data   = data_q;
    assign busy_flag = bf_q;
    assign addr_cnt  = ac_q;
    assign LCD_RS    = rs_q;
    assign LCD_RW    = rw_q;
    assign LCD_EN    = en_q;
    assign bus_oe    = oe_q;
`ifdef LCD_READER_AUTOPOLL_EN
    assign lcd_idle  = idle_q;
`endif

endmodule

// File: tb/tb_lcd_reader.sv
// tb/tb_lcd_reader.sv - scoreboard bench for lcd_reader with a cycle-accurate LCD bus model
module tb_lcd_reader;
    localparam int SETUP_CYC   = 20;
    localparam int EN_HIGH_CYC = 75;
    localparam int SAMPLE_CYC  = 40;
    localparam int HOLD_CYC    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] bus = 8'h00;
    logic [7:0] bus_in;
    logic       ready, rd_valid, busy_flag, LCD_RS, LCD_RW, LCD_EN, bus_oe;
    logic [7:0] rd_data;
    logic [6:0] addr_cnt;
`ifdef LCD_READER_AUTOPOLL_EN
    logic       poll_req = 1'b0;
    logic       lcd_idle;
`endif

    lcd_reader dut (
        .clk(clk), .rst(rst), .req(req), .req_rs(req_rs),
`ifdef LCD_READER_AUTOPOLL_EN
        .poll_req(poll_req), .lcd_idle(lcd_idle),
`endif
        .ready(ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy_flag(busy_flag), .addr_cnt(addr_cnt),
        .LCD_DataBus_in(bus_in), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .bus_oe(bus_oe)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    int en_age = 0;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        en_age <= LCD_EN ? en_age + 1 : 0;
    end

    // LCD drives the real byte only in the EN-high cycle the reader should sample; garbage otherwise
    assign bus_in = (LCD_EN && en_age == SAMPLE_CYC) ? bus : ~bus;

    typedef struct {
        logic [7:0] data;
        logic       bf;
        logic [6:0] ac;
        int         acc;
        logic       idle;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    logic m_bf = 1'b1;
    logic [6:0] m_ac = 7'h00;
    int   en_rises = 0;
    int   rv_count = 0;
    int   cur_acc = -1;
    logic cur_rs = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Monitor: checks protocol timing and pops the scoreboard on every rd_valid
    int   rise_cyc = 0;
    int   last_rv_cyc = -1;
    logic en_p = 1'b0;
    logic rdy_p = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            en_p        = LCD_EN;
            rdy_p       = ready;
            last_rv_cyc = -1;
        end else begin
            chk("oe_vs_rw", {31'd0, bus_oe}, {31'd0, ~LCD_RW});
            if (LCD_RW) chk("rs_during_read", {31'd0, LCD_RS}, {31'd0, cur_rs});
            if (LCD_EN && !en_p) begin
                en_rises++;
                rise_cyc = cyc;
                chk("rw_at_en_rise", {31'd0, LCD_RW}, 32'd1);
                if (cur_acc >= 0) chk("en_rise_delay", cyc - cur_acc, SETUP_CYC + 1);
            end
            if (!LCD_EN && en_p) chk("en_width", cyc - rise_cyc, EN_HIGH_CYC);
            if (rd_valid) begin
                rv_count++;
                last_rv_cyc = cyc;
                if (sbq.size() == 0) begin
                    timeout("unexpected_rd_valid");
                end else begin
                    e = sbq.pop_front();
                    chk("rd_data", {24'd0, rd_data}, {24'd0, e.data});
                    chk("busy_flag", {31'd0, busy_flag}, {31'd0, e.bf});
                    chk("addr_cnt", {25'd0, addr_cnt}, {25'd0, e.ac});
                    if (e.acc >= 0) chk("rv_latency", cyc - e.acc, SETUP_CYC + EN_HIGH_CYC + 1);
`ifdef LCD_READER_AUTOPOLL_EN
                    chk("lcd_idle", {31'd0, lcd_idle}, {31'd0, e.idle});
`endif
                end
            end
            if (ready && !rdy_p && last_rv_cyc >= 0) chk("ready_after_rv", cyc - last_rv_cyc, HOLD_CYC);
            en_p  = LCD_EN;
            rdy_p = ready;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) timeout("wait_ready");
    endtask

    // Reference model: BF/AC follow the last RS=0 byte; data is always the raw byte
    task automatic push_exp(input logic rs, input logic [7:0] b, input int acc, input logic idle);
        exp_t e;
        if (!rs) begin
            m_bf = b[7];
            m_ac = b[6:0];
        end
        e.data = b;
        e.bf   = m_bf;
        e.ac   = m_ac;
        e.acc  = acc;
        e.idle = idle;
        sbq.push_back(e);
    endtask

    task automatic start_read(input logic rs, input logic [7:0] b);
        wait_ready();
        bus     = b;
        req_rs  = rs;
        req     = 1'b1;
        cur_acc = cyc;
        cur_rs  = rs;
        push_exp(rs, b, cyc, 1'b0);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic do_read(input logic rs, input logic [7:0] b);
        start_read(rs, b);
        wait_ready();
    endtask

    initial begin
        int n_en, n_rv, n;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rw", {31'd0, LCD_RW}, 32'd0);
        chk("rst_en", {31'd0, LCD_EN}, 32'd0);
        chk("rst_rs", {31'd0, LCD_RS}, 32'd0);
        chk("rst_oe", {31'd0, bus_oe}, 32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_rv", {31'd0, rd_valid}, 32'd0);
        chk("rst_data", {24'd0, rd_data}, 32'd0);
        chk("rst_bf", {31'd0, busy_flag}, 32'd1);
        chk("rst_ac", {25'd0, addr_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_read(1'b0, 8'h85);
        chk("bf_after_85", {31'd0, busy_flag}, 32'd1);
        chk("ac_after_85", {25'd0, addr_cnt}, 32'h05);

        do_read(1'b1, 8'h31);
        chk("data_31", {24'd0, rd_data}, 32'h31);
        chk("bf_kept", {31'd0, busy_flag}, 32'd1);
        chk("ac_kept", {25'd0, addr_cnt}, 32'h05);

        for (int i = 0; i < 8; i++) begin
            do_read(1'($urandom_range(0, 1)), 8'($urandom));
        end

        // req chatter during EN high must not start or queue another read
        n_en = en_rises;
        n_rv = rv_count;
        start_read(1'($urandom_range(0, 1)), 8'($urandom));
        n = 0;
        while (!LCD_EN && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!LCD_EN) timeout("wait_en");
        for (int i = 0; i < 30; i++) begin
            req    = 1'($urandom_range(0, 1));
            req_rs = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        req = 1'b0;
        wait_ready();
        chk("ignored_req_en_pulses", en_rises - n_en, 1);
        chk("ignored_req_rd_valids", rv_count - n_rv, 1);

        // Reset in the middle of EN high: EN drops, no result, stored values cleared
        start_read(1'b0, 8'h12);
        repeat (SETUP_CYC + 49) @(posedge clk);
        #1;
        chk("en_before_reset", {31'd0, LCD_EN}, 32'd1);
        rst = 1'b1;
        sbq.delete();
        m_bf = 1'b1;
        m_ac = 7'h00;
        @(posedge clk); #1;
        chk("midrst_en", {31'd0, LCD_EN}, 32'd0);
        chk("midrst_rw", {31'd0, LCD_RW}, 32'd0);
        chk("midrst_oe", {31'd0, bus_oe}, 32'd1);
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_rv", {31'd0, rd_valid}, 32'd0);
        chk("midrst_data", {24'd0, rd_data}, 32'd0);
        chk("midrst_bf", {31'd0, busy_flag}, 32'd1);
        chk("midrst_ac", {25'd0, addr_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        n_rv = rv_count;
        repeat (100) @(posedge clk);
        #1;
        chk("no_rv_after_reset", rv_count - n_rv, 0);

        do_read(1'b1, 8'($urandom));
        chk("bf_after_reset_data", {31'd0, busy_flag}, 32'd1);
        chk("ac_after_reset_data", {25'd0, addr_cnt}, 32'd0);
        do_read(1'b0, 8'($urandom));

`ifdef LCD_READER_AUTOPOLL_EN
        begin
            logic [7:0] vals [4];
            int ready_seen;
            for (int k = 0; k < 4; k++) begin
                vals[k] = (k < 3) ? (8'h80 | 8'($urandom_range(0, 127))) : 8'h00;
                push_exp(1'b0, vals[k], -1, (k == 3));
            end
            wait_ready();
            n_en     = en_rises;
            cur_acc  = -1;
            cur_rs   = 1'b0;
            bus      = vals[0];
            poll_req = 1'b1;
            req      = 1'b1;
            req_rs   = 1'b1;
            @(posedge clk); #1;
            poll_req = 1'b0;
            req      = 1'b0;
            ready_seen = 0;
            for (int k = 0; k < 4; k++) begin
                n = 0;
                do begin
                    @(posedge clk); #1;
                    if (ready) ready_seen++;
                    n++;
                end while (!rd_valid && n < 300);
                if (!rd_valid) timeout("poll_rd_valid");
                if (k < 3) bus = vals[k + 1];
            end
            chk("poll_ready_low", ready_seen, 0);
            wait_ready();
            chk("poll_en_pulses", en_rises - n_en, 4);
        end
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
